// File: rtl/imem_arbiter_pkg.sv
// Shared constants for the instruction-memory arbiter: FSM encoding, default
// geometry and the address legality check used by both grant requesters.
package imem_arbiter_pkg;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

  localparam int DEPTH_DEFAULT      = 100;
  localparam int STARVE_MAX_DEFAULT = 4;

  // Word-aligned and inside the memory window; limit is DEPTH*4 bytes.
  function automatic logic addr_illegal(input logic [31:0] addr, input logic [31:0] limit);
    return (addr[1:0] != 2'b00) || (addr >= limit);
  endfunction

endpackage

// File: rtl/imem_grant_ctrl.sv
// Grant decision and fetch-starvation counter for the instruction-memory port.
// Grants are combinational; only the starve counter is state.
module imem_grant_ctrl
  import imem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  arb_state_e state_i,
  input  logic       fetch_req_i,
  input  logic       load_req_i,
  output logic       fetch_gnt_o,
  output logic       load_gnt_o
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [CW-1:0] starve_q, starve_d;

  // Grants are suppressed while reset is held so nothing reaches memory.
  always_comb begin
    fetch_gnt_o = 1'b0;
    load_gnt_o  = 1'b0;
    if (rst_ni) begin
      if (state_i == ST_BOOT) begin
        load_gnt_o = load_req_i;
      end else if (fetch_req_i && (!load_req_i || starve_q == STARVE_LIM)) begin
        fetch_gnt_o = 1'b1;
      end else begin
        load_gnt_o = load_req_i;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (state_i != ST_RUN || !fetch_req_i || fetch_gnt_o) begin
      starve_d = '0;
    end else if (load_gnt_o && starve_q != STARVE_LIM) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: serves the boot loader exclusively in BOOT, then
// shares the single memory port between loader writes and instruction fetches.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEFAULT,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_done_i,
  input  logic        fetch_req_i,
  input  logic [31:0] fetch_addr_i,
  output logic        fetch_gnt_o,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_instr_o,
  input  logic        load_req_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_data_i,
  output logic        load_gnt_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o,
  output arb_state_e  state_o
);

  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

  arb_state_e  state_q;
  logic        fetch_gnt, load_gnt;
  logic        ill_fetch, ill_load;
  logic [31:0] mem_addr_q, wdata_q, instr_q;
  logic        valid_q, err_q;

  imem_grant_ctrl #(
    .STARVE_MAX (STARVE_MAX)
  ) u_grant (
    .clk_i       (clk_i),
    .rst_ni      (rst_i),
    .state_i     (state_q),
    .fetch_req_i (fetch_req_i),
    .load_req_i  (load_req_i),
    .fetch_gnt_o (fetch_gnt),
    .load_gnt_o  (load_gnt)
  );

  assign ill_fetch = addr_illegal(fetch_addr_i, ADDR_LIMIT);
  assign ill_load  = addr_illegal(load_addr_i, ADDR_LIMIT);

  // The memory port follows the granted requester; on idle cycles it keeps the last address.
  always_comb begin
    mem_addr_o  = mem_addr_q;
    mem_wdata_o = wdata_q;
    mem_we_o    = 1'b0;
    if (fetch_gnt) begin
      mem_addr_o = fetch_addr_i;
    end else if (load_gnt) begin
      mem_addr_o  = load_addr_i;
      mem_wdata_o = load_data_i;
      mem_we_o    = !ill_load;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_BOOT;
      mem_addr_q <= '0;
      wdata_q    <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (state_q == ST_BOOT && load_done_i) begin
        state_q <= ST_RUN;
      end
      if (fetch_gnt || load_gnt) begin
        mem_addr_q <= mem_addr_o;
      end
      if (load_gnt) begin
        wdata_q <= load_data_i;
      end
      // An illegal fetch still completes, returning zero instead of memory data.
      if (fetch_gnt) begin
        instr_q <= ill_fetch ? 32'h0 : mem_rdata_i;
      end
      valid_q <= fetch_gnt;
      if ((fetch_gnt && ill_fetch) || (load_gnt && ill_load)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign fetch_gnt_o   = fetch_gnt;
  assign load_gnt_o    = load_gnt;
  assign fetch_valid_o = valid_q;
  assign fetch_instr_o = instr_q;
  assign err_o         = err_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a small behavioural instruction memory.
module tb_imem_arbiter;
  import imem_arbiter_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        load_done_i;
  logic        fetch_req_i;
  logic [31:0] fetch_addr_i;
  logic        fetch_gnt_o;
  logic        fetch_valid_o;
  logic [31:0] fetch_instr_o;
  logic        load_req_i;
  logic [31:0] load_addr_i;
  logic [31:0] load_data_i;
  logic        load_gnt_o;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        err_o;
  arb_state_e  state_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] tb_mem [0:127] = '{default: 32'hDEAD_BEEF};

  imem_arbiter #(
    .DEPTH      (100),
    .STARVE_MAX (4)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .load_done_i   (load_done_i),
    .fetch_req_i   (fetch_req_i),
    .fetch_addr_i  (fetch_addr_i),
    .fetch_gnt_o   (fetch_gnt_o),
    .fetch_valid_o (fetch_valid_o),
    .fetch_instr_o (fetch_instr_o),
    .load_req_i    (load_req_i),
    .load_addr_i   (load_addr_i),
    .load_data_i   (load_data_i),
    .load_gnt_o    (load_gnt_o),
    .mem_addr_o    (mem_addr_o),
    .mem_we_o      (mem_we_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_rdata_i   (mem_rdata_i),
    .err_o         (err_o),
    .state_o       (state_o)
  );

  // Clock and memory model
  always #5 clk_i = ~clk_i;

  assign mem_rdata_i = tb_mem[mem_addr_o[8:2]];

  always @(posedge clk_i) begin
    if (mem_we_o) tb_mem[mem_addr_o[8:2]] <= mem_wdata_o;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Inputs change 2ns after the rising edge; checks run 1ns after that.
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic idle_inputs();
    load_done_i  = 1'b0;
    fetch_req_i  = 1'b0;
    fetch_addr_i = 32'h0;
    load_req_i   = 1'b0;
    load_addr_i  = 32'h0;
    load_data_i  = 32'h0;
  endtask

  task automatic drive_fetch(input logic [31:0] addr);
    fetch_req_i  = 1'b1;
    fetch_addr_i = addr;
  endtask

  task automatic drive_load(input logic [31:0] addr, input logic [31:0] data);
    load_req_i  = 1'b1;
    load_addr_i = addr;
    load_data_i = data;
  endtask

  string pattern = "LLLLFLLLLF";

  initial begin
    rst_i = 1'b0;
    idle_inputs();
    drive_load(32'h4, 32'h1111_1111);
    #3;
    check("rst_state", 32'(state_o), 32'(ST_BOOT));
    check("rst_we", 32'(mem_we_o), 32'h0);
    check("rst_load_gnt", 32'(load_gnt_o), 32'h0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_wdata", mem_wdata_o, 32'h0);
    check("rst_valid", 32'(fetch_valid_o), 32'h0);
    check("rst_instr", fetch_instr_o, 32'h0);
    check("rst_err", 32'(err_o), 32'h0);
    tick();
    tick();
    rst_i = 1'b1;
    idle_inputs();

    // BOOT ignores fetch requests
    for (int i = 0; i < 5; i++) begin
      drive_fetch(32'h0);
      #1;
      check("boot_fetch_gnt", 32'(fetch_gnt_o), 32'h0);
      check("boot_fetch_valid", 32'(fetch_valid_o), 32'h0);
      tick();
    end
    idle_inputs();

    // Loader write in BOOT
    drive_load(32'h4, 32'h2008_0005);
    #1;
    check("boot_load_gnt", 32'(load_gnt_o), 32'h1);
    check("boot_we", 32'(mem_we_o), 32'h1);
    check("boot_addr", mem_addr_o, 32'h4);
    check("boot_wdata", mem_wdata_o, 32'h2008_0005);
    tick();

    // Final write together with load_done
    drive_load(32'h8, 32'h0000_1234);
    load_done_i = 1'b1;
    #1;
    check("done_we", 32'(mem_we_o), 32'h1);
    check("done_state_pre", 32'(state_o), 32'(ST_BOOT));
    tick();
    idle_inputs();
    #1;
    check("run_state", 32'(state_o), 32'(ST_RUN));
    check("done_write_mem", tb_mem[2], 32'h0000_1234);

    // Back-to-back fetches
    drive_fetch(32'h4);
    #1;
    check("fetch_gnt", 32'(fetch_gnt_o), 32'h1);
    check("fetch_we", 32'(mem_we_o), 32'h0);
    check("fetch_addr", mem_addr_o, 32'h4);
    tick();
    drive_fetch(32'h8);
    #1;
    check("b2b_valid0", 32'(fetch_valid_o), 32'h1);
    check("b2b_instr0", fetch_instr_o, 32'h2008_0005);
    check("b2b_gnt1", 32'(fetch_gnt_o), 32'h1);
    tick();
    idle_inputs();
    #1;
    check("b2b_valid1", 32'(fetch_valid_o), 32'h1);
    check("b2b_instr1", fetch_instr_o, 32'h0000_1234);
    check("idle_addr_hold", mem_addr_o, 32'h8);
    check("idle_we", 32'(mem_we_o), 32'h0);
    tick();
    #1;
    check("idle_valid", 32'(fetch_valid_o), 32'h0);
    check("idle_instr_hold", fetch_instr_o, 32'h0000_1234);

    // Starvation limit
    for (int i = 0; i < 10; i++) begin
      drive_load(32'h10, 32'h0000_0055);
      drive_fetch(32'h4);
      #1;
      check($sformatf("starve_fetch_gnt%0d", i), 32'(fetch_gnt_o), 32'(pattern[i] == "F"));
      check($sformatf("starve_load_gnt%0d", i), 32'(load_gnt_o), 32'(pattern[i] == "L"));
      tick();
    end
    idle_inputs();
    tick();

    // Illegal addresses
    #1;
    check("err_before", 32'(err_o), 32'h0);
    drive_fetch(32'h2);
    #1;
    check("ill_fetch_gnt", 32'(fetch_gnt_o), 32'h1);
    tick();
    drive_fetch(32'h190);
    #1;
    check("ill_err_set", 32'(err_o), 32'h1);
    check("ill_valid0", 32'(fetch_valid_o), 32'h1);
    check("ill_instr0", fetch_instr_o, 32'h0);
    check("ill_range_gnt", 32'(fetch_gnt_o), 32'h1);
    tick();
    idle_inputs();
    drive_load(32'h3, 32'hCAFE_F00D);
    #1;
    check("ill_valid1", 32'(fetch_valid_o), 32'h1);
    check("ill_instr1", fetch_instr_o, 32'h0);
    check("ill_load_gnt", 32'(load_gnt_o), 32'h1);
    check("ill_load_we", 32'(mem_we_o), 32'h0);
    tick();
    idle_inputs();
    tick();
    #1;
    check("err_sticky", 32'(err_o), 32'h1);

    // Reset arriving before the fetch response is captured
    drive_fetch(32'h4);
    #1;
    check("rstmid_gnt", 32'(fetch_gnt_o), 32'h1);
    rst_i = 1'b0;
    drive_load(32'h4, 32'h7777_7777);
    #1;
    check("rstmid_gnt_off", 32'(fetch_gnt_o), 32'h0);
    check("rstmid_we", 32'(mem_we_o), 32'h0);
    check("rstmid_addr", mem_addr_o, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      check("rstmid_valid", 32'(fetch_valid_o), 32'h0);
      check("rstmid_instr", fetch_instr_o, 32'h0);
      check("rstmid_err", 32'(err_o), 32'h0);
      check("rstmid_state", 32'(state_o), 32'(ST_BOOT));
      check("rstmid_wdata", mem_wdata_o, 32'h0);
    end
    check("rstmid_mem_intact", tb_mem[1], 32'h2008_0005);
    rst_i = 1'b1;
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter DEPTH, default 100, instruction memory depth in 32-bit words.
REQ-002 Parameter STARVE_MAX, default 4, maximum consecutive loader grants while fetch waits.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low.
REQ-005 load_done_i  input  1  loader finished; leave boot phase.
REQ-006 fetch_req_i  input  1  fetch request.
REQ-007 fetch_addr_i  input  32  fetch byte address.
REQ-008 fetch_gnt_o  output  1  fetch request accepted this cycle.
REQ-009 fetch_valid_o  output  1  fetch_instr_o valid.
REQ-010 fetch_instr_o  output  32  fetched instruction.
REQ-011 load_req_i  input  1  loader write request.
REQ-012 load_addr_i  input  32  loader byte address.
REQ-013 load_data_i  input  32  loader write data.
REQ-014 load_gnt_o  output  1  loader write accepted this cycle.
REQ-015 mem_addr_o  output  32  byte address to instruction memory.
REQ-016 mem_we_o  output  1  memory write enable.
REQ-017 mem_wdata_o  output  32  memory write data.
REQ-018 mem_rdata_i  input  32  combinational memory read data.
REQ-019 err_o  output  1  sticky address-error flag.

Function
REQ-020 FSM states BOOT, RUN; BOOT→RUN on the edge where load_done_i=1; RUN is terminal until reset.
REQ-021 BOOT: only loader served; fetch_gnt_o=0 regardless of fetch_req_i.
REQ-022 RUN arbitration, at most one grant per cycle: loader wins by default; fetch wins if fetch_req_i=1 and starve counter == STARVE_MAX.
REQ-023 Starve counter: increments on loader grant while fetch_req_i=1 (saturating at STARVE_MAX); clears on fetch grant or when fetch_req_i=0.
REQ-024 Grants are combinational from current requests and state; a request with its address flagged illegal (REQ-028) is still granted but produces no memory write.
REQ-025 Loader grant: mem_addr_o=load_addr_i, mem_wdata_o=load_data_i, mem_we_o=1 in the same cycle.
REQ-026 Fetch grant: mem_addr_o=fetch_addr_i, mem_we_o=0; mem_rdata_i registered into fetch_instr_o; fetch_valid_o=1 exactly one cycle later, for one cycle.
REQ-027 Idle cycle (no grant): mem_we_o=0, mem_addr_o holds last value, fetch_instr_o holds last value.
REQ-028 Illegal address: bits[1:0]≠0 or address ≥ DEPTH*4; err_o set on the next edge, remains 1 until reset; illegal fetch returns fetch_instr_o=0 with fetch_valid_o=1.
REQ-029 Simultaneous load_done_i and load_req_i in BOOT: write is performed, then RUN entered.
REQ-030 Back-to-back fetch grants yield fetch_valid_o every cycle (full throughput, latency 1).

Reset
REQ-031 While rst_i=0: state=BOOT, starve counter=0, fetch_valid_o=0, fetch_instr_o=0, err_o=0, mem_addr_o=0, mem_we_o=0, mem_wdata_o=0.
REQ-032 Reset asserted mid-fetch cancels the pending fetch_valid_o; no write occurs while rst_i=0.

Structure
REQ-033 State encoding, DEPTH default and STARVE_MAX default live in the shared CPU constants package.
REQ-034 Starve counter and grant logic form one sub-module, imem_grant_ctrl; datapath muxing and response register stay in imem_arbiter.

Verification
REQ-035 Reset, BOOT, fetch_req_i=1 at 0x0 for 5 cycles → fetch_gnt_o=0 throughout, no fetch_valid_o.
REQ-036 BOOT loader writes 0x20080005 to 0x4, load_done_i, then fetch 0x4 → mem_we_o=1 at write, fetch_valid_o one cycle after grant with 0x20080005.
REQ-037 RUN, load_req_i and fetch_req_i held high 10 cycles, STARVE_MAX=4 → grant pattern L,L,L,L,F repeating.
REQ-038 Fetch 0x2 then fetch 0x190 (DEPTH=100) → err_o=1 after first, fetch_instr_o=0 both, err_o stays 1.
REQ-039 Reset asserted the cycle after a fetch grant → fetch_valid_o never rises, all outputs zero, state BOOT.
